// File: rtl/vigna_icache_wt_pkg.sv
// rtl/vigna_icache_wt_pkg.sv - shared constants and helpers for the vigna write-through cache
// Purpose: FSM state encodings, default MMIO boundary and a byte-enable mask helper.
// Ports: none (package).
package vigna_icache_wt_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOOKUP = 2'd1;
   localparam logic [1:0] ST_MEM    = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic [31:0] DEFAULT_UNCACHED_BASE = 32'h8000_0000;

   // Expand a 4-bit byte enable into a 32-bit bit mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++) begin
         m[b*8 +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/vigna_icache_wt_line_store.sv
// rtl/vigna_icache_wt_line_store.sv - valid/tag/data arrays of the direct-mapped cache
// Purpose: per-line storage with a combinational read port and one write port.
// Ports:
//   clk         in   clock
//   i_clear     in   synchronous clear of every valid bit (wins over a same-cycle fill)
//   i_rd_index  in   read index; o_rd_valid/o_rd_tag/o_rd_data follow combinationally
//   i_wr_en     in   write strobe
//   i_wr_fill   in   1 = refill (set valid, tag, whole word); 0 = byte merge into data only
//   i_wr_index  in   write index
//   i_wr_tag    in   tag written on refill
//   i_wr_data   in   write data
//   i_wr_be     in   byte enables used in merge mode
module vigna_icache_wt_line_store
   import vigna_icache_wt_pkg::*;
#(
   parameter int LINES = 16,
   localparam int INDEX_BITS = $clog2(LINES),
   localparam int TAG_BITS = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  i_clear,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output logic                  o_rd_valid,
   output logic [TAG_BITS-1:0]   o_rd_tag,
   output logic [31:0]           o_rd_data,
   input  logic                  i_wr_en,
   input  logic                  i_wr_fill,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  logic [TAG_BITS-1:0]   i_wr_tag,
   input  logic [31:0]           i_wr_data,
   input  logic [3:0]            i_wr_be
);

   logic [LINES-1:0]    r_valid;
   logic [TAG_BITS-1:0] r_tag  [LINES];
   logic [31:0]         r_data [LINES];
   logic [31:0]         w_mask;

   assign w_mask = byte_mask(i_wr_fill ? 4'hF : i_wr_be);

   // Clear has priority so a flush landing on a refill edge still leaves the line invalid.
   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_valid <= '0;
      end else if (i_wr_en && i_wr_fill) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en && i_wr_fill) begin
         r_tag[i_wr_index] <= i_wr_tag;
      end
      if (i_wr_en) begin
         r_data[i_wr_index] <= (r_data[i_wr_index] & ~w_mask) | (i_wr_data & w_mask);
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/vigna_icache_wt.sv
// rtl/vigna_icache_wt.sv - direct-mapped word-line write-through cache for the vigna bus
// Purpose: 1-cycle read hits, single-word refill on miss, write-through without allocate,
//          MMIO (>= UNCACHED_BASE) passed straight to memory.
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   flush                    1-cycle pulse, invalidates all lines (deferred to IDLE if busy)
//   s_valid/s_ready          CPU request / 1-cycle completion pulse
//   s_addr/s_wdata/s_wstrb   CPU byte address, write data, byte enables (0 = read)
//   s_rdata                  read data, valid with s_ready
//   m_valid/m_ready          registered memory request / memory completion pulse
//   m_addr/m_wdata/m_wstrb   word-aligned address, write data, byte enables (0 = read)
//   m_rdata                  memory read data, valid with m_ready
module vigna_icache_wt
   import vigna_icache_wt_pkg::*;
#(
   parameter int          LINES         = 16,
   parameter logic [31:0] UNCACHED_BASE = DEFAULT_UNCACHED_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_addr,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   output logic [31:0] s_rdata,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] m_rdata
);

   localparam int INDEX_BITS = $clog2(LINES);
   localparam int TAG_BITS   = 30 - INDEX_BITS;

   logic [1:0]  r_state;
   logic [29:0] r_word;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_flush_pend;
   logic        r_s_ready;
   logic [31:0] r_s_rdata;
   logic        r_m_valid;
   logic [31:0] r_m_addr;
   logic [31:0] r_m_wdata;
   logic [3:0]  r_m_wstrb;

   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_BITS-1:0]   w_tag;
   logic                  w_line_valid;
   logic [TAG_BITS-1:0]   w_line_tag;
   logic [31:0]           w_line_data;
   logic                  w_uncached;
   logic                  w_is_read;
   logic                  w_hit;
   logic                  w_flush_apply;
   logic                  w_accept;
   logic                  w_mem_done;
   logic                  w_wr_en;
   logic                  w_unused_addr_lsbs;

   assign w_unused_addr_lsbs = ^s_addr[1:0];

   assign w_index    = r_word[INDEX_BITS-1:0];
   assign w_tag      = r_word[29:INDEX_BITS];
   assign w_uncached = ({r_word, 2'b00} >= UNCACHED_BASE);
   assign w_is_read  = (r_wstrb == 4'h0);
   assign w_hit      = w_line_valid && (w_line_tag == w_tag) && !w_uncached;

   // A pending or fresh flush is applied in IDLE and costs that cycle's accept.
   assign w_flush_apply = (r_state == ST_IDLE) && (flush || r_flush_pend);
   // While the hit-path s_ready pulse is out, the CPU is still presenting the old request.
   assign w_accept   = (r_state == ST_IDLE) && s_valid && !r_s_ready && !w_flush_apply;
   assign w_mem_done = (r_state == ST_MEM) && m_ready;
   // Only cached reads refill and cached write hits merge; write misses and MMIO leave lines alone.
   assign w_wr_en    = w_mem_done && !w_uncached && (w_is_read || w_hit);

   vigna_icache_wt_line_store #(.LINES(LINES)) u_store (
      .clk        (clk),
      .i_clear    (reset | w_flush_apply),
      .i_rd_index (w_index),
      .o_rd_valid (w_line_valid),
      .o_rd_tag   (w_line_tag),
      .o_rd_data  (w_line_data),
      .i_wr_en    (w_wr_en),
      .i_wr_fill  (w_is_read),
      .i_wr_index (w_index),
      .i_wr_tag   (w_tag),
      .i_wr_data  (w_is_read ? m_rdata : r_wdata),
      .i_wr_be    (r_wstrb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_word       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_flush_pend <= 1'b0;
         r_s_ready    <= 1'b0;
         r_s_rdata    <= '0;
         r_m_valid    <= 1'b0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
         r_m_wstrb    <= '0;
      end else begin
         if (w_flush_apply) begin
            r_flush_pend <= 1'b0;
         end else if (flush) begin
            r_flush_pend <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_s_ready <= 1'b0;
               if (w_accept) begin
                  r_word  <= s_addr[31:2];
                  r_wdata <= s_wdata;
                  r_wstrb <= s_wstrb;
                  r_state <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (w_is_read && w_hit) begin
                  r_s_ready <= 1'b1;
                  r_s_rdata <= w_line_data;
                  r_state   <= ST_IDLE;
               end else begin
                  r_m_valid <= 1'b1;
                  r_m_addr  <= {r_word, 2'b00};
                  r_m_wdata <= r_wdata;
                  r_m_wstrb <= r_wstrb;
                  r_state   <= ST_MEM;
               end
            end
            ST_MEM: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_s_rdata <= w_is_read ? m_rdata : 32'h0;
                  r_state   <= ST_RESP;
               end
            end
            default: begin
               r_s_ready <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_ready = r_s_ready;
   assign s_rdata = r_s_rdata;
   assign m_valid = r_m_valid;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign m_wstrb = r_m_wstrb;

endmodule
